// File: rtl/spi_master_param_if.sv
// Processor-side request/response bundle for spi_master_param.
// The lsb_first signal exists only when SPI_LSB_FIRST_EN is defined.
interface spi_master_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CS_W   = 1
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [CS_W-1:0]   cs_sel;
  logic [1:0]        mode;
  logic              hold_cs;
`ifdef SPI_LSB_FIRST_EN
  logic              lsb_first;
`endif
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;

`ifdef SPI_LSB_FIRST_EN
  modport master (output tx_data, tx_valid, cs_sel, mode, hold_cs, lsb_first,
                  input  tx_ready, rx_data, rx_valid, busy);
  modport slave  (input  tx_data, tx_valid, cs_sel, mode, hold_cs, lsb_first,
                  output tx_ready, rx_data, rx_valid, busy);
`else
  modport master (output tx_data, tx_valid, cs_sel, mode, hold_cs,
                  input  tx_ready, rx_data, rx_valid, busy);
  modport slave  (input  tx_data, tx_valid, cs_sel, mode, hold_cs,
                  output tx_ready, rx_data, rx_valid, busy);
`endif
endinterface

// File: rtl/spi_master_param.sv
// Parametrised SPI master: per-transfer CPOL/CPHA, multiple chip selects, CS-held bursts.
// Optional macro SPI_LSB_FIRST_EN adds an LSB-first transfer option (bus.lsb_first).
module spi_master_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV    = 4,
  parameter int unsigned NUM_CS = 2
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_param_if.slave bus,
  output logic              sck_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic [NUM_CS-1:0] cs_n_o
);
  localparam int unsigned CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int unsigned CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned EDGE_W = $clog2(2 * DATA_W);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEAD  = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_TRAIL = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] rxsh_q, rxsh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [1:0]        mode_q, mode_d;
  logic [CS_W-1:0]   cs_sel_q, cs_sel_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              rx_valid_q, rx_valid_d;
  logic              busy_q, busy_d;
  logic              tx_ready_q, tx_ready_d;

  logic              tick_c, odd_edge_c, last_edge_c, sample_c, shift_en_c;
  logic [DATA_W-1:0] shift_c, rx_next_c;

`ifdef SPI_LSB_FIRST_EN
  logic lsb_q, lsb_d;

  always_ff @(posedge clk) begin
    if (rst) lsb_q <= 1'b0;
    else     lsb_q <= lsb_d;
  end
`else
  logic lsb_q;
  assign lsb_q = 1'b0;
`endif

  function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  // Edge bookkeeping: edge_q holds the 0-based index of the next SCK edge.
  assign tick_c      = (cnt_q == CNT_W'(DIV - 1));
  assign odd_edge_c  = ~edge_q[0];
  assign last_edge_c = (edge_q == EDGE_W'(2 * DATA_W - 1));
  assign sample_c    = mode_q[0] ? ~odd_edge_c : odd_edge_c;
  assign shift_en_c  = ~sample_c;
  assign shift_c     = lsb_q ? {1'b0, shreg_q[DATA_W-1:1]} : {shreg_q[DATA_W-2:0], 1'b0};
  assign rx_next_c   = lsb_q ? {miso_i, rxsh_q[DATA_W-1:1]} : {rxsh_q[DATA_W-2:0], miso_i};

  always_comb begin
    state_d    = state_q;
    edge_d     = edge_q;
    shreg_d    = shreg_q;
    rxsh_d     = rxsh_q;
    rx_data_d  = rx_data_q;
    mode_d     = mode_q;
    cs_sel_d   = cs_sel_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;
`ifdef SPI_LSB_FIRST_EN
    lsb_d      = lsb_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.tx_valid) begin
          shreg_d  = bus.tx_data;
          mode_d   = bus.mode;
          cs_sel_d = bus.cs_sel;
`ifdef SPI_LSB_FIRST_EN
          lsb_d    = bus.lsb_first;
`endif
          state_d  = S_LEAD;
        end
      end
      S_LEAD: begin
        if (tick_c) begin
          state_d = S_XFER;
          edge_d  = '0;
          if (!mode_q[0]) mosi_d = first_bit(shreg_q, lsb_q);
        end
      end
      S_XFER: begin
        if (tick_c) begin
          sck_d  = ~sck_q;
          edge_d = edge_q + EDGE_W'(1);
          if (sample_c) rxsh_d = rx_next_c;
          if (shift_en_c) begin
            shreg_d = shift_c;
            mosi_d  = mode_q[0] ? first_bit(shreg_q, lsb_q) : first_bit(shift_c, lsb_q);
          end
          if (last_edge_c) begin
            edge_d     = '0;
            rx_data_d  = rxsh_d;
            rx_valid_d = 1'b1;
            state_d    = bus.hold_cs ? S_HOLD : S_TRAIL;
          end
        end
      end
      S_HOLD: begin
        // A new word beats a dropped hold_cs; mode and target stay as latched.
        if (bus.tx_valid) begin
          shreg_d = bus.tx_data;
          edge_d  = '0;
          state_d = S_XFER;
          if (!mode_q[0]) mosi_d = first_bit(bus.tx_data, lsb_q);
        end else if (!bus.hold_cs) begin
          state_d = S_TRAIL;
        end
      end
      S_TRAIL: begin
        if (tick_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q == S_IDLE) || (state_q == S_HOLD) || tick_c) cnt_d = '0;
    else                                                      cnt_d = cnt_q + CNT_W'(1);

    if (state_d != S_XFER) sck_d = mode_d[1];

    busy_d     = (state_d != S_IDLE);
    tx_ready_d = (state_d == S_IDLE) || (state_d == S_HOLD);
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      cs_n_d[i] = !((state_d != S_IDLE) && (cs_sel_d == CS_W'(i)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      edge_q     <= '0;
      shreg_q    <= '0;
      rxsh_q     <= '0;
      rx_data_q  <= '0;
      mode_q     <= 2'b00;
      cs_sel_q   <= '0;
      cs_n_q     <= '1;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      shreg_q    <= shreg_d;
      rxsh_q     <= rxsh_d;
      rx_data_q  <= rx_data_d;
      mode_q     <= mode_d;
      cs_sel_q   <= cs_sel_d;
      cs_n_q     <= cs_n_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  assign bus.tx_ready = tx_ready_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = busy_q;
  assign sck_o        = sck_q;
  assign mosi_o       = mosi_q;
  assign cs_n_o       = cs_n_q;
endmodule
